// File: rtl/bidir_pad_drv.sv
// Core-side bidirectional pad controller: register file for pad controls, input
// synchronizer with change capture, and a post-reset settle FSM that holds pads safe.
module bidir_pad_drv #(
    parameter int NUM_BIDIR_PADS = 8,
    parameter int SETTLE_CYCLES  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [2:0]                wr_addr,
    input  logic [31:0]               wr_data,
    input  logic [2:0]                rd_addr,
    output logic [31:0]               rd_data,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
    output logic [NUM_BIDIR_PADS-1:0] bidir_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic                      active
);

    localparam int N = NUM_BIDIR_PADS;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [N-1:0]   out_q, oe_q, ie_q, pu_q, pd_q, cs_q, sl_q;
    logic [N-1:0]   out_d, oe_d, ie_d, pu_d, pd_d, cs_d, sl_d;
    logic [N-1:0]   chg_q, chg_d;
    logic [N-1:0]   sync1_q, sync2_q, prev_q;
    logic [N-1:0]   pad_out_q, pad_oe_q, pad_ie_q, pad_pu_q, pad_pd_q, pad_cs_q, pad_sl_q;
    logic [N-1:0]   pad_out_d, pad_oe_d, pad_ie_d, pad_pu_d, pad_pd_d, pad_cs_d, pad_sl_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic           active_q;
    logic           wr_en_s;
    logic [N-1:0]   wdata_s;
    logic [N-1:0]   clr_s;
    logic [N-1:0]   rd_sel_s;
    logic           unused_s;

    assign wr_ready = 1'b1;
    assign wr_en_s  = wr_valid;
    assign wdata_s  = wr_data[N-1:0];
    // Upper write-data bits are intentionally ignored when fewer than 32 pads exist.
    assign unused_s = ^wr_data;

    // Settle FSM next state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_SETTLE;
        endcase
    end

    // Control register writes; address 7 toggles OUT and supplies the CHG clear mask.
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        ie_d  = ie_q;
        pu_d  = pu_q;
        pd_d  = pd_q;
        cs_d  = cs_q;
        sl_d  = sl_q;
        clr_s = '0;
        if (wr_en_s) begin
            case (wr_addr)
                3'd0:    out_d = wdata_s;
                3'd1:    oe_d  = wdata_s;
                3'd2:    ie_d  = wdata_s;
                3'd3:    pu_d  = wdata_s;
                3'd4:    pd_d  = wdata_s;
                3'd5:    cs_d  = wdata_s;
                3'd6:    sl_d  = wdata_s;
                3'd7: begin
                    out_d = out_q ^ wdata_s;
                    clr_s = wdata_s;
                end
                default: out_d = out_q;
            endcase
        end else begin
            clr_s = '0;
        end
        // A fresh input edge outranks a simultaneous software clear.
        chg_d = (chg_q & ~clr_s) | (sync2_q ^ prev_q);
    end

    // Pad drive values: safe defaults until the FSM is (about to be) ACTIVE.
    always_comb begin
        pad_out_d = '0;
        pad_oe_d  = '0;
        pad_ie_d  = {N{1'b1}};
        pad_pu_d  = '0;
        pad_pd_d  = '0;
        pad_cs_d  = '0;
        pad_sl_d  = '0;
        if (state_d == ST_ACTIVE) begin
            pad_out_d = out_q;
            pad_oe_d  = oe_q;
            pad_ie_d  = ie_q;
            pad_pu_d  = pu_q & ~pd_q;
            pad_pd_d  = pd_q;
            pad_cs_d  = cs_q;
            pad_sl_d  = sl_q;
        end else begin
            pad_ie_d  = {N{1'b1}};
        end
    end

    // Read mux, zero-extended to 32 bits.
    always_comb begin
        rd_sel_s = '0;
        case (rd_addr)
            3'd0:    rd_sel_s = sync2_q;
            3'd1:    rd_sel_s = oe_q;
            3'd2:    rd_sel_s = ie_q;
            3'd3:    rd_sel_s = pu_q;
            3'd4:    rd_sel_s = pd_q;
            3'd5:    rd_sel_s = cs_q;
            3'd6:    rd_sel_s = sl_q;
            3'd7:    rd_sel_s = chg_q;
            default: rd_sel_s = '0;
        endcase
        rd_data_d = 32'd0;
        rd_data_d[N-1:0] = rd_sel_s;
    end

    // All state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= 8'd0;
            out_q     <= '0;
            oe_q      <= '0;
            ie_q      <= '0;
            pu_q      <= '0;
            pd_q      <= '0;
            cs_q      <= '0;
            sl_q      <= '0;
            chg_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pad_out_q <= '0;
            pad_oe_q  <= '0;
            pad_ie_q  <= {N{1'b1}};
            pad_pu_q  <= '0;
            pad_pd_q  <= '0;
            pad_cs_q  <= '0;
            pad_sl_q  <= '0;
            rd_data_q <= 32'd0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            ie_q      <= ie_d;
            pu_q      <= pu_d;
            pd_q      <= pd_d;
            cs_q      <= cs_d;
            sl_q      <= sl_d;
            chg_q     <= chg_d;
            sync1_q   <= bidir_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
            pad_ie_q  <= pad_ie_d;
            pad_pu_q  <= pad_pu_d;
            pad_pd_q  <= pad_pd_d;
            pad_cs_q  <= pad_cs_d;
            pad_sl_q  <= pad_sl_d;
            rd_data_q <= rd_data_d;
            active_q  <= (state_d == ST_ACTIVE);
        end
    end

    assign bidir_out = pad_out_q;
    assign bidir_oe  = pad_oe_q;
    assign bidir_ie  = pad_ie_q;
    assign bidir_pu  = pad_pu_q;
    assign bidir_pd  = pad_pd_q;
    assign bidir_cs  = pad_cs_q;
    assign bidir_sl  = pad_sl_q;
    assign rd_data   = rd_data_q;
    assign active    = active_q;

endmodule

// File: tb/tb_bidir_pad_drv.sv
// Directed self-checking bench for bidir_pad_drv (8 pads, 16 settle cycles).
module tb_bidir_pad_drv;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  bidir_in;
    logic [7:0]  bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic        active;

    int n_cmp;
    int n_bad;

    bidir_pad_drv #(.NUM_BIDIR_PADS(8), .SETTLE_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .bidir_in(bidir_in),
        .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
        .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
        .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        rd_addr = a;
        tick();
        check_val(tag, rd_data, exp);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 32'd0;
        rd_addr  = 3'd0;
        bidir_in = 8'h00;
        tick();
        tick();
        check_val("rst_oe", {24'd0, bidir_oe}, 32'h0);
        check_val("rst_ie", {24'd0, bidir_ie}, 32'hFF);
        check_val("rst_active", {31'd0, active}, 32'h0);
        check_val("rst_rd", rd_data, 32'h0);
        check_val("wr_ready", {31'd0, wr_ready}, 32'h1);
        rst = 1'b0;

        // Settle: writes land in registers but pads stay safe until ACTIVE.
        for (int i = 1; i <= 16; i++) begin
            if (i == 1) begin
                wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 32'h0000_00FF;
            end else if (i == 2) begin
                wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFA5;
            end else begin
                wr_valid = 1'b0;
            end
            tick();
            check_val("settle_active", {31'd0, active}, (i == 16) ? 32'h1 : 32'h0);
            check_val("settle_oe", {24'd0, bidir_oe}, (i == 16) ? 32'hFF : 32'h0);
            check_val("settle_out", {24'd0, bidir_out}, (i == 16) ? 32'hA5 : 32'h0);
        end
        wr_valid = 1'b0;
        rd_check("rd_oe", 3'd1, 32'hFF);
        rd_check("rd_chg_idle", 3'd7, 32'h0);

        // Toggle OUT: 0xA5 ^ 0x0F, visible one edge after the write edge.
        wr(3'd7, 32'h0F);
        check_val("tgl_out_k", {24'd0, bidir_out}, 32'hA5);
        tick();
        check_val("tgl_out_k1", {24'd0, bidir_out}, 32'hAA);

        // Pull conflict: pull-down wins.
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'h0F);
        tick();
        check_val("pu", {24'd0, bidir_pu}, 32'hF0);
        check_val("pd", {24'd0, bidir_pd}, 32'h0F);

        // Input edge on bit 3 sets CHG two edges after the 2-flop sync; clear same edge.
        bidir_in = 8'h08;
        tick();
        tick();
        wr(3'd7, 32'h08);
        rd_check("chg_set_wins", 3'd7, 32'h08);
        rd_check("rd_sync", 3'd0, 32'h08);
        wr(3'd7, 32'h08);
        rd_check("chg_cleared", 3'd7, 32'h00);
        check_val("out_after_2tgl", {24'd0, bidir_out}, 32'hAA);

        // Mid-operation reset clears pads immediately, then settle reruns.
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_oe", {24'd0, bidir_oe}, 32'h0);
        check_val("arst_active", {31'd0, active}, 32'h0);
        check_val("arst_ie", {24'd0, bidir_ie}, 32'hFF);
        check_val("arst_pd", {24'd0, bidir_pd}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i >= 15) begin
                check_val("resettle_active", {31'd0, active}, (i == 16) ? 32'h1 : 32'h0);
            end
        end
        check_val("resettle_oe", {24'd0, bidir_oe}, 32'h0);
        rd_check("resettle_oe_reg", 3'd1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
